// File: rtl/axil_cmd_master_if.sv
// Command, response and AXI-Lite master channel bundle for axil_cmd_master.
// Modport master is the bridge side; slave is the initiator/interconnect side.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic [STRB_WIDTH-1:0] cmd_wstrb_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_we_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic [1:0]            rsp_resp_o;

  logic [ADDR_WIDTH-1:0] m_awaddr_o;
  logic                  m_awvalid_o;
  logic                  m_awready_i;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic [STRB_WIDTH-1:0] m_wstrb_o;
  logic                  m_wvalid_o;
  logic                  m_wready_i;
  logic [1:0]            m_bresp_i;
  logic                  m_bvalid_i;
  logic                  m_bready_o;
  logic [ADDR_WIDTH-1:0] m_araddr_o;
  logic                  m_arvalid_o;
  logic                  m_arready_i;
  logic [DATA_WIDTH-1:0] m_rdata_i;
  logic [1:0]            m_rresp_i;
  logic                  m_rvalid_i;
  logic                  m_rready_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_resp_o,
    output m_awaddr_o, m_awvalid_o, input m_awready_i,
    output m_wdata_o, m_wstrb_o, m_wvalid_o, input m_wready_i,
    input  m_bresp_i, m_bvalid_i, output m_bready_o,
    output m_araddr_o, m_arvalid_o, input m_arready_i,
    input  m_rdata_i, m_rresp_i, m_rvalid_i, output m_rready_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_resp_o,
    input  m_awaddr_o, m_awvalid_o, output m_awready_i,
    input  m_wdata_o, m_wstrb_o, m_wvalid_o, output m_wready_i,
    output m_bresp_i, m_bvalid_i, input m_bready_o,
    input  m_araddr_o, m_arvalid_o, output m_arready_i,
    output m_rdata_i, m_rresp_i, m_rvalid_i, input m_rready_o
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Turns a single read/write command stream into one AXI-Lite master transaction at a time.
// Define AXIL_CMD_MASTER_STATS_EN to add write/read/error transaction counters.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef AXIL_CMD_MASTER_STATS_EN
  input  logic        stat_clr_i,
  output logic [31:0] stat_wr_cnt_o,
  output logic [31:0] stat_rd_cnt_o,
  output logic [15:0] stat_err_cnt_o,
`endif
  axil_cmd_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  // Every output is a flop; the whole set resets to zero in one assignment.
  typedef struct packed {
    logic                  cmd_ready;
    logic                  rsp_valid;
    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  rready;
  } out_t;

  state_t r_state, w_state_nxt;
  out_t   r_out, w_out_nxt;
  logic   w_b_hs, w_r_hs;

  assign w_b_hs = (r_state == WR_RESP) && bus.m_bvalid_i && r_out.bready;
  assign w_r_hs = (r_state == RD_DATA) && bus.m_rvalid_i && r_out.rready;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state <= IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults come first (hold current values) so no path leaves a variable unassigned and infers a latch.
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid_i && r_out.cmd_ready) begin
          w_out_nxt.cmd_ready = 1'b0;
          w_out_nxt.rsp_we    = bus.cmd_we_i;
          if (bus.cmd_we_i) begin
            w_out_nxt.awaddr  = bus.cmd_addr_i;
            w_out_nxt.wdata   = bus.cmd_wdata_i;
            w_out_nxt.wstrb   = bus.cmd_wstrb_i;
            w_out_nxt.awvalid = 1'b1;
            w_out_nxt.wvalid  = 1'b1;
            w_state_nxt       = WR_REQ;
          end else begin
            w_out_nxt.araddr  = bus.cmd_addr_i;
            w_out_nxt.arvalid = 1'b1;
            w_state_nxt       = RD_REQ;
          end
        end else begin
          w_out_nxt.cmd_ready = 1'b1;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; B is only accepted once both have gone.
        if (bus.m_awready_i) w_out_nxt.awvalid = 1'b0;
        if (bus.m_wready_i)  w_out_nxt.wvalid  = 1'b0;
        if (!w_out_nxt.awvalid && !w_out_nxt.wvalid) begin
          w_out_nxt.bready = 1'b1;
          w_state_nxt      = WR_RESP;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_out_nxt.bready    = 1'b0;
          w_out_nxt.rsp_rdata = '0;
          w_out_nxt.rsp_resp  = bus.m_bresp_i;
          w_out_nxt.rsp_valid = 1'b1;
          w_state_nxt         = RSP;
        end
      end
      RD_REQ: begin
        if (bus.m_arready_i) begin
          w_out_nxt.arvalid = 1'b0;
          w_out_nxt.rready  = 1'b1;
          w_state_nxt       = RD_DATA;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          w_out_nxt.rready    = 1'b0;
          w_out_nxt.rsp_rdata = bus.m_rdata_i;
          w_out_nxt.rsp_resp  = bus.m_rresp_i;
          w_out_nxt.rsp_valid = 1'b1;
          w_state_nxt         = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready_i) begin
          w_out_nxt.rsp_valid = 1'b0;
          w_out_nxt.cmd_ready = 1'b1;
          w_state_nxt         = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready_o = r_out.cmd_ready;
  assign bus.rsp_valid_o = r_out.rsp_valid;
  assign bus.rsp_we_o    = r_out.rsp_we;
  assign bus.rsp_rdata_o = r_out.rsp_rdata;
  assign bus.rsp_resp_o  = r_out.rsp_resp;
  assign bus.m_awaddr_o  = r_out.awaddr;
  assign bus.m_awvalid_o = r_out.awvalid;
  assign bus.m_wdata_o   = r_out.wdata;
  assign bus.m_wstrb_o   = r_out.wstrb;
  assign bus.m_wvalid_o  = r_out.wvalid;
  assign bus.m_bready_o  = r_out.bready;
  assign bus.m_araddr_o  = r_out.araddr;
  assign bus.m_arvalid_o = r_out.arvalid;
  assign bus.m_rready_o  = r_out.rready;

`ifdef AXIL_CMD_MASTER_STATS_EN
  logic [31:0] r_wr_cnt, r_rd_cnt;
  logic [15:0] r_err_cnt;
  logic        w_err;

  assign w_err = (w_b_hs && (bus.m_bresp_i != 2'b00)) || (w_r_hs && (bus.m_rresp_i != 2'b00));

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_b_hs) r_wr_cnt  <= r_wr_cnt + 32'd1;
      if (w_r_hs) r_rd_cnt  <= r_rd_cnt + 32'd1;
      if (w_err)  r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign stat_wr_cnt_o  = r_wr_cnt;
  assign stat_rd_cnt_o  = r_rd_cnt;
  assign stat_err_cnt_o = r_err_cnt;
`endif
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Upstream neighbour of the AXI-Lite RAM/register slaves: turns a simple valid/ready command stream (single read or write) into one AXI-Lite master transaction, then returns the result on a response stream.
- Sits between bus initiators (UART/SPI debug bridges, sequencers) and the AXI-Lite interconnect or slave.
- At most one transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; multiple of 8; STRB_WIDTH = DATA_WIDTH/8.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  byte address
cmd_wdata_i  in  DATA_WIDTH  write data
cmd_wstrb_i  in  STRB_WIDTH  write strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_we_o  out  1  echo of cmd_we
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
rsp_resp_o  out  2  BRESP/RRESP
m_awaddr_o  out  ADDR_WIDTH  AW address
m_awvalid_o  out  1  AW valid
m_awready_i  in  1  AW ready
m_wdata_o  out  DATA_WIDTH  W data
m_wstrb_o  out  STRB_WIDTH  W strobes
m_wvalid_o  out  1  W valid
m_wready_i  in  1  W ready
m_bresp_i  in  2  B response
m_bvalid_i  in  1  B valid
m_bready_o  out  1  B ready
m_araddr_o  out  ADDR_WIDTH  AR address
m_arvalid_o  out  1  AR valid
m_arready_i  in  1  AR ready
m_rdata_i  in  DATA_WIDTH  R data
m_rresp_i  in  2  R response
m_rvalid_i  in  1  R valid
m_rready_o  out  1  R ready

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: all outputs 0, including cmd_ready_o, all valid/ready outputs, addresses, data, rsp_*. FSM goes to IDLE.
- Reset mid-transaction: abandons the transaction and returns to IDLE; the interconnect is reset alongside.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready_o=1 (registered); it is 1 only in IDLE.
  - On cmd_valid_i & cmd_ready_o, latch addr/wdata/wstrb/we.
  - Go to WR_REQ with m_awvalid_o=m_wvalid_o=1 next cycle, or to RD_REQ with m_arvalid_o=1 next cycle.
  - Issue latency: 1 cycle.
- WR_REQ:
  - AW and W are independent; each valid drops the cycle after its own handshake.
  - Both may complete in either order or the same cycle.
  - When both are done, go to WR_RESP with m_bready_o=1.
  - Valids and payload stay stable until handshake.
- WR_RESP: on m_bvalid_i & m_bready_o, capture bresp, set rsp_rdata_o=0, drop m_bready_o, go to RSP.
- RD_REQ: on m_arready_i, drop m_arvalid_o, raise m_rready_o, go to RD_DATA.
- RD_DATA: on m_rvalid_i & m_rready_o, capture rdata and rresp, drop m_rready_o, go to RSP.
- RSP:
  - rsp_valid_o=1; rsp_* stable while rsp_ready_i=0.
  - On handshake, rsp_valid_o=0, go to IDLE; cmd_ready_o=1 the following cycle.
  - A new command cannot be accepted in the response-handshake cycle.
- Ready signals are never asserted before their state. B/R beats arriving early wait until m_bready_o/m_rready_o are asserted.
- Non-OKAY responses (2'b10, 2'b11) are passed through unchanged; no retry.
- Address is passed unmodified; no alignment check.

Optional Feature:
- Macro: AXIL_CMD_MASTER_STATS_EN.
- Defined: adds outputs stat_wr_cnt_o[31:0], stat_rd_cnt_o[31:0] and stat_err_cnt_o[15:0].
  - The write and read counters increment on each B/R handshake.
  - The error counter increments when resp != 2'b00.
  - All counters wrap modulo 2^N, clear on rst_i and are cleared by an extra input stat_clr_i (1 cycle, priority over increment).
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Write to axil_ram model: cmd we=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Expect AW and W asserted 1 cycle after accept.
  - Expect rsp_valid_o with resp=0, rdata=0.
  - A following read of 0x10 returns 0xDEADBEEF, resp=0.
- Split AW/W: slave raises wready 3 cycles before awready.
  - Expect m_wvalid_o to drop after the W handshake while m_awvalid_o holds until its handshake.
  - Exactly one B accepted.
- Backpressure: rsp_ready_i=0 for 5 cycles after read (rdata=0x12345678).
  - rsp_* stable throughout; cmd_ready_o stays 0 until 1 cycle after the rsp handshake.
- Error path: slave returns rresp=2'b10.
  - rsp_resp_o=2'b10.
  - With STATS_EN, stat_err_cnt_o increments to 1 and stat_rd_cnt_o to 1.
- Reset mid-write: assert rst_i while in WR_RESP.
  - All outputs 0 the next cycle; cmd_ready_o=1 one cycle after rst_i deasserts.
  - A subsequent write completes normally.
- Back-to-back: 4 alternating write/read commands with cmd_valid_i held high.
  - Each accepted only in IDLE, completes in order, with correct data and resp=0.
